// File: rtl/keypoint_read_scheduler_if.sv
// SRAM read ports and downstream valid/ready channel of the keypoint read scheduler.
// master = scheduler side, slave = SRAM/descriptor-engine side.
interface keypoint_read_scheduler_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 19
);
  logic [ADDR_W-1:0] kp1_addr;
  logic [ADDR_W-1:0] kp2_addr;
  logic [DATA_W-1:0] kp1_dout;
  logic [DATA_W-1:0] kp2_dout;
  logic              kp_valid;
  logic              kp_ready;
  logic [DATA_W-1:0] kp_data;
  logic              kp_layer;

  modport master (
    output kp1_addr, kp2_addr, kp_valid, kp_data, kp_layer,
    input  kp1_dout, kp2_dout, kp_ready
  );

  modport slave (
    input  kp1_addr, kp2_addr, kp_valid, kp_data, kp_layer,
    output kp1_dout, kp2_dout, kp_ready
  );
endinterface

// File: rtl/keypoint_read_scheduler.sv
// Drains the layer-0 and layer-1 keypoint SRAMs into a single valid/ready stream,
// alternating layers while both have entries left.
module keypoint_read_scheduler #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 19,
  parameter int KP_DEPTH = 2048
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start_i,
  input  logic [11:0]                     kp1_count_i,
  input  logic [11:0]                     kp2_count_i,
  keypoint_read_scheduler_if.master       kp_if,
  output logic                            busy_o,
  output logic                            done_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [11:0] DEPTH_C = 12'(KP_DEPTH);

  function automatic logic [11:0] sat_count(input logic [11:0] c);
    if (c > DEPTH_C) begin
      return DEPTH_C;
    end else begin
      return c;
    end
  endfunction

  state_t            state_q, state_d;
  logic [11:0]       cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [11:0]       ptr0_q, ptr0_d, ptr1_q, ptr1_d;
  logic              prio_q, prio_d, sel_q, sel_d;
  logic              valid_q, valid_d, layer_q, layer_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic              rem0_s, rem1_s, more_s;
  logic [11:0]       sat0_s, sat1_s;

  assign kp_if.kp1_addr = ptr0_q[ADDR_W-1:0];
  assign kp_if.kp2_addr = ptr1_q[ADDR_W-1:0];
  assign kp_if.kp_valid = valid_q;
  assign kp_if.kp_data  = data_q;
  assign kp_if.kp_layer = layer_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt0_q  <= 12'd0;
      cnt1_q  <= 12'd0;
      ptr0_q  <= 12'd0;
      ptr1_q  <= 12'd0;
      prio_q  <= 1'b0;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      layer_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      ptr0_q  <= ptr0_d;
      ptr1_q  <= ptr1_d;
      prio_q  <= prio_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      layer_q <= layer_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    ptr0_d  = ptr0_q;
    ptr1_d  = ptr1_q;
    prio_d  = prio_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    layer_d = layer_q;
    data_d  = data_q;
    more_s  = 1'b0;
    rem0_s  = (ptr0_q < cnt0_q);
    rem1_s  = (ptr1_q < cnt1_q);
    sat0_s  = sat_count(kp1_count_i);
    sat1_s  = sat_count(kp2_count_i);

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cnt0_d = sat0_s;
          cnt1_d = sat1_s;
          ptr0_d = 12'd0;
          ptr1_d = 12'd0;
          prio_d = 1'b0;
          if ((sat0_s == 12'd0) && (sat1_s == 12'd0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (prio_q ? rem1_s : rem0_s) begin
          sel_d = prio_q;
        end else begin
          sel_d = ~prio_q;
        end
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // SRAM sampled the address at the ISSUE->WAIT edge, so dout is valid now.
        data_d  = sel_q ? kp_if.kp2_dout : kp_if.kp1_dout;
        layer_d = sel_q;
        valid_d = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (kp_if.kp_ready) begin
          valid_d = 1'b0;
          prio_d  = ~sel_q;
          if (sel_q) begin
            ptr1_d = ptr1_q + 12'd1;
            more_s = rem0_s || ((ptr1_q + 12'd1) < cnt1_q);
          end else begin
            ptr0_d = ptr0_q + 12'd1;
            more_s = rem1_s || ((ptr0_q + 12'd1) < cnt0_q);
          end
          state_d = more_s ? ST_ISSUE : ST_DONE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

endmodule
